// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader.
// Optional feature: LOADER_CHECKSUM_EN adds the trailing checksum byte and the CHECK state.
package loader_pkg;

  // Counter width for a given number of bytes per word; never narrower than one bit.
  function automatic int unsigned byte_cnt_width(input int unsigned bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  localparam int unsigned DEFAULT_INSTRUCTION_WIDTH = 32;
  localparam int unsigned BYTES_PER_WORD = DEFAULT_INSTRUCTION_WIDTH / 8;
  localparam int unsigned BYTE_CNT_WIDTH = byte_cnt_width(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRecv  = 3'd1,
    StWrite = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    StCheck = 3'd3,
`endif
    StDone  = 3'd4
  } loader_state_e;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte stream, memory write port and status bundle of the instruction loader.
// master: the host side (start request and byte source); slave: the loader itself.
interface instruction_loader_if #(
  parameter int unsigned PC_WIDTH          = 18,
  parameter int unsigned INSTRUCTION_WIDTH = 32
);
  logic                         start;
  logic [PC_WIDTH-1:0]          word_count;
  logic [7:0]                   byte_in;
  logic                         byte_valid;
  logic                         byte_ready;
  logic                         mem_we;
  logic [PC_WIDTH-1:0]          mem_addr;
  logic [INSTRUCTION_WIDTH-1:0] mem_wdata;
  logic                         fetch_hold;
  logic                         busy;
  logic                         done;
  logic                         error;

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, fetch_hold, busy, done, error
  );

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, fetch_hold, busy, done, error
  );
endinterface

// File: rtl/instruction_loader_byte_assembler.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
// 'word' shows the assembled value including a byte accepted this cycle, so the
// parent can capture a complete word on the same edge that takes its last byte.
module byte_assembler
  import loader_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         accept,
  input  logic [7:0]                   byte_in,
  output logic [INSTRUCTION_WIDTH-1:0] word,
  output logic                         word_complete
);
  localparam int unsigned BytesPerWord = INSTRUCTION_WIDTH / 8;
  localparam int unsigned CntWidth     = byte_cnt_width(BytesPerWord);
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(BytesPerWord - 1);

  logic [CntWidth-1:0]          cnt_q, cnt_d;
  logic [INSTRUCTION_WIDTH-1:0] word_q, word_d;

  // Place the incoming byte at the current slot and advance the byte counter.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      word_d[{cnt_q, 3'b000} +: 8] = byte_in;
      cnt_d = (cnt_q == LastIdx) ? '0 : cnt_q + 1'b1;
    end
  end

  assign word          = word_d;
  assign word_complete = accept && (cnt_q == LastIdx);

  // Byte counter and shift/placement register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Instruction loader: streams bytes into instruction memory, one word per write,
// holding the fetch stage off while a load is in progress.
// Optional feature: LOADER_CHECKSUM_EN consumes one trailing XOR checksum byte
// after the last word and raises error in DONE on mismatch.
module instruction_loader
  import loader_pkg::*;
#(
  parameter int unsigned PC_WIDTH          = 18,
  parameter int unsigned INSTRUCTION_WIDTH = 32
) (
  input logic                 clock,
  input logic                 reset,
  instruction_loader_if.slave bus
);
  loader_state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]          addr_q, addr_d;
  logic [PC_WIDTH-1:0]          count_q, count_d;
  logic [PC_WIDTH-1:0]          addr_inc;
  logic [PC_WIDTH-1:0]          mem_addr_q, mem_addr_d;
  logic [INSTRUCTION_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                         start_ok;
  logic                         data_accept;
  logic [INSTRUCTION_WIDTH-1:0] asm_word;
  logic                         asm_complete;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]                   csum_q, csum_d;
  logic                         error_q, error_d;
`endif

  assign start_ok    = bus.start && ((state_q == StIdle) || (state_q == StDone));
  assign data_accept = (state_q == StRecv) && bus.byte_valid;
  assign addr_inc    = addr_q + 1'b1;

  byte_assembler #(
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
  ) u_byte_assembler (
    .clock         (clock),
    .reset         (reset),
    .clear         (start_ok),
    .accept        (data_accept),
    .byte_in       (bus.byte_in),
    .word          (asm_word),
    .word_complete (asm_complete)
  );

  // Next-state, address/count bookkeeping and write-port capture.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
    error_d     = error_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          count_d = bus.word_count;
          addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
          error_d = 1'b0;
`endif
          state_d = (bus.word_count == '0) ? StDone : StRecv;
        end
      end
      StRecv: begin
        if (bus.byte_valid) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.byte_in;
`endif
          if (asm_complete) begin
            // Capture here so the write port holds steady outside the pulse.
            mem_addr_d  = addr_q;
            mem_wdata_d = asm_word;
            state_d     = StWrite;
          end
        end
      end
      StWrite: begin
        addr_d = addr_inc;
        if (addr_inc == count_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StRecv;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (bus.byte_valid) begin
          error_d = (bus.byte_in != csum_q);
          state_d = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State, counters and write-port registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of data bytes and the latched checksum verdict.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else begin
      csum_q  <= csum_d;
      error_q <= error_d;
    end
  end
`endif

  // Status and handshake outputs decoded from the state register.
  always_comb begin
    bus.mem_we     = (state_q == StWrite);
    bus.mem_addr   = mem_addr_q;
    bus.mem_wdata  = mem_wdata_q;
    bus.done       = (state_q == StDone);
`ifdef LOADER_CHECKSUM_EN
    bus.byte_ready = (state_q == StRecv) || (state_q == StCheck);
    bus.busy       = (state_q == StRecv) || (state_q == StWrite) || (state_q == StCheck);
    bus.error      = error_q;
`else
    bus.byte_ready = (state_q == StRecv);
    bus.busy       = (state_q == StRecv) || (state_q == StWrite);
    bus.error      = 1'b0;
`endif
    bus.fetch_hold = bus.busy;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameters SHALL be: PC_WIDTH, default 18, instruction memory address width; INSTRUCTION_WIDTH, default 32, instruction word width (must be a multiple of 8).
REQ-002 Ports SHALL be:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load.
- word_count  in  PC_WIDTH  number of words to load; sampled when start is accepted.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts byte_in this cycle.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  PC_WIDTH  write address.
- mem_wdata  out  INSTRUCTION_WIDTH  write data.
- fetch_hold  out  1  keeps the fetch stage disabled during a load.
- busy  out  1  load in progress.
- done  out  1  last load completed.
- error  out  1  checksum mismatch.

Function
REQ-003 The FSM SHALL have states IDLE, RECV, WRITE, CHECK and DONE; CHECK SHALL exist only under REQ-014.
REQ-004 In IDLE or DONE, start=1 SHALL latch word_count, clear the address and byte counters, clear done and error, and enter RECV, or DONE if word_count=0.
REQ-005 start SHALL be ignored while busy=1.
REQ-006 A byte SHALL transfer only on a rising edge where byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 only in RECV (and CHECK).
REQ-007 Bytes SHALL be assembled little-endian: the first byte of a word goes to bits [7:0] and byte k goes to bits [8k+7:8k].
REQ-008 When byte INSTRUCTION_WIDTH/8 of a word is accepted, the FSM SHALL enter WRITE.
- In the next cycle, mem_we=1 for exactly one cycle, with mem_addr equal to the current word index and mem_wdata equal to the assembled word.
REQ-009 After WRITE, the address SHALL increment by 1.
- If the words written equal the latched word_count, the FSM enters DONE (or CHECK under REQ-014).
- Otherwise it returns to RECV.
- The address never wraps, since the maximum count is 2^PC_WIDTH-1.
REQ-010 busy and fetch_hold SHALL be 1 in RECV, WRITE and CHECK, and 0 in IDLE and DONE.
REQ-011 done SHALL be 1 in DONE and held until the next accepted start or reset.
REQ-012 Gaps in byte_valid SHALL stall assembly without losing state; no timeout exists.
REQ-013 mem_addr and mem_wdata SHALL hold their values when mem_we=0.

Configuration
REQ-014 With LOADER_CHECKSUM_EN defined:
- After the last WRITE, the FSM enters CHECK and accepts one extra byte.
- error is set to 1 in DONE if that byte differs from the XOR of all data bytes of the load.
REQ-015 Without LOADER_CHECKSUM_EN, CHECK and the checksum register SHALL be absent, error SHALL be tied to 0, and no trailing byte is consumed.

Reset
REQ-016 reset=0 SHALL asynchronously force:
- state IDLE;
- all counters, mem_addr and mem_wdata to 0;
- mem_we, byte_ready, busy, fetch_hold, done and error to 0.
REQ-017 Reset asserted mid-load SHALL abort the load with no further mem_we pulse; words already written remain in memory.

Structure
REQ-018 Package loader_pkg SHALL hold:
- the state enum type;
- the BYTES_PER_WORD constant (INSTRUCTION_WIDTH/8);
- the byte-counter width constant.
REQ-019 A single sub-module, byte_assembler, SHALL hold the byte shift/placement register and byte counter, and flag word-complete; the FSM, address counter and checksum SHALL reside in instruction_loader.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Basic load: word_count=2, bytes 78 56 34 12 EF BE AD DE, valid every cycle -> writes addr 0 = 0x12345678, then addr 1 = 0xDEADBEEF, each mem_we one cycle; then done=1, fetch_hold=0.
- Zero count: start with word_count=0 -> DONE on the next edge, no mem_we, byte_ready stays 0.
- Gappy stream: one word with byte_valid toggling 1,0,0,1,... -> same data written once; byte_ready=0 during WRITE.
- Start while busy: a second start mid-load with word_count=5 is ignored -> the original count completes.
- Mid-load reset: reset=0 after 6 of 8 bytes -> all outputs 0 immediately; no write to addr 1; a fresh start loads correctly.
- Checksum (LOADER_CHECKSUM_EN): bytes 01 02 03 04, checksum 04 -> error=0; checksum 05 -> error=1 with done=1.
